diff_prog_delay_line: RTL and testbench

//  Multi-lane differential delay line with a runtime-programmable depth, for aligning/skewing

---
 rtl/diff_delay_pkg.sv | 27 ++
 rtl/diff_delay_lane.sv | 52 +++++
 rtl/diff_prog_delay_line.sv | 127 ++++++++++++
 tb/tb_diff_prog_delay_line.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/diff_delay_pkg.sv
// Shared types, reset constants and delay clamping for the differential delay line.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package diff_delay_pkg;

    // Reprogramming FSM: IDLE passes data through, SETTLE masks outputs while the line refills
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Idle level of a differential pair: p low, n high (a valid differential 0)
    localparam logic P_RST = 1'b0;
    localparam logic N_RST = 1'b1;

    // Legal depths are 2..max_delay; anything outside is pinned to the nearest bound
    function automatic int clamp_delay(input int sel, input int max_delay);
        if (sel < 2) begin
            return 2;
        end else if (sel > max_delay) begin
            return max_delay;
        end else begin
            return sel;
        end
    endfunction

endpackage

// File: rtl/diff_delay_lane.sv
// One lane's p/n shift chain with a depth-selectable combinational tap.
// Latency: tap shows the input sampled (i_tap_sel-1) edges earlier; output register in the top adds one.
// Backpressure: none, the chain shifts every cycle unconditionally.
module diff_delay_lane
    import diff_delay_pkg::*;
#(
    parameter int MAX_DELAY = 16,
    parameter int DELAY_W   = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_p,
    input  logic               i_n,
    input  logic [DELAY_W-1:0] i_tap_sel,
    output logic               o_tap_p,
    output logic               o_tap_n
);

    // The top's output register supplies the last stage, so MAX_DELAY-1 stages suffice
    localparam int STAGES = MAX_DELAY - 1;

    logic [STAGES-1:0] r_p;
    logic [STAGES-1:0] r_n;

    // Shift both legs one stage per cycle; reset fills the chain with the idle pair
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_p <= {STAGES{P_RST}};
            r_n <= {STAGES{N_RST}};
        end else begin
            r_p[0] <= i_p;
            r_n[0] <= i_n;
            for (int k = 1; k < STAGES; k++) begin
                r_p[k] <= r_p[k-1];
                r_n[k] <= r_n[k-1];
            end
        end
    end

    // Tap stage (i_tap_sel-2); the top guarantees i_tap_sel is within 2..MAX_DELAY
    always_comb begin
        o_tap_p = r_p[0];
        o_tap_n = r_n[0];
        for (int k = 0; k < STAGES; k++) begin
            if (int'(i_tap_sel) == k + 2) begin
                o_tap_p = r_p[k];
                o_tap_n = r_n[k];
            end
        end
    end

endmodule

// File: rtl/diff_prog_delay_line.sv
// Multi-lane differential delay line with runtime-programmable depth (optional per-lane invalid-pair counters under DIFF_DELAY_ERR_CNT_EN).
// Latency: exactly o_cur_delay cycles from i_in_* to o_out_*.
// Backpressure: none; i_delay_load is ignored while o_delay_busy is high (no queueing).
module diff_prog_delay_line
    import diff_delay_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int MAX_DELAY = 16,
    parameter int DELAY_W   = 5,
    parameter int CNT_W     = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [LANES-1:0]       i_in_p,
    input  logic [LANES-1:0]       i_in_n,
    input  logic [DELAY_W-1:0]     i_delay_sel,
    input  logic                   i_delay_load,
    output logic                   o_delay_busy,
    output logic [DELAY_W-1:0]     o_cur_delay,
    output logic [LANES-1:0]       o_out_p,
    output logic [LANES-1:0]       o_out_n,
    output logic [LANES-1:0]       o_out_valid
`ifdef DIFF_DELAY_ERR_CNT_EN
    ,
    input  logic                   i_err_clr,
    output logic [LANES*CNT_W-1:0] o_err_cnt
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_cur_delay;
    logic [DELAY_W-1:0] r_settle_cnt;
    logic [DELAY_W-1:0] w_clamped;
    logic               w_load;
    logic [LANES-1:0]   w_tap_p;
    logic [LANES-1:0]   w_tap_n;
    logic [LANES-1:0]   r_out_p;
    logic [LANES-1:0]   r_out_n;

    assign w_clamped = DELAY_W'(clamp_delay(int'(i_delay_sel), MAX_DELAY));
    assign w_load    = (r_state == IDLE) && i_delay_load;

    // Per-lane shift chains, all tapped at the depth currently in effect
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        diff_delay_lane #(
            .MAX_DELAY (MAX_DELAY),
            .DELAY_W   (DELAY_W)
        ) u_lane (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_p       (i_in_p[l]),
            .i_n       (i_in_n[l]),
            .i_tap_sel (r_cur_delay),
            .o_tap_p   (w_tap_p[l]),
            .o_tap_n   (w_tap_n[l])
        );
    end

    // FSM state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a load starts SETTLE, which ends after the counter reaches 1
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_delay_load) w_state_nxt = SETTLE;
            SETTLE:  if (r_settle_cnt == DELAY_W'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Depth in effect and refill counter; SETTLE therefore lasts exactly the new depth
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cur_delay  <= DELAY_W'(MAX_DELAY);
            r_settle_cnt <= '0;
        end else if (w_load) begin
            r_cur_delay  <= w_clamped;
            r_settle_cnt <= w_clamped;
        end else if (r_state == SETTLE) begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
        end
    end

    // Output register follows the tap in IDLE and holds its last value while settling
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out_p <= {LANES{P_RST}};
            r_out_n <= {LANES{N_RST}};
        end else if (r_state == IDLE) begin
            r_out_p <= w_tap_p;
            r_out_n <= w_tap_n;
        end
    end

    assign o_delay_busy = (r_state == SETTLE);
    assign o_cur_delay  = r_cur_delay;
    assign o_out_p      = r_out_p;
    assign o_out_n      = r_out_n;
    assign o_out_valid  = (r_state == IDLE) ? (r_out_p ^ r_out_n) : '0;

`ifdef DIFF_DELAY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_err
        // Count cycles where the incoming pair is not differential; saturate, clear has priority
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_err_cnt[l] <= '0;
            end else if (i_err_clr) begin
                r_err_cnt[l] <= '0;
            end else if ((i_in_p[l] == i_in_n[l]) && (r_err_cnt[l] != {CNT_W{1'b1}})) begin
                r_err_cnt[l] <= r_err_cnt[l] + 1'b1;
            end
        end
        assign o_err_cnt[l*CNT_W +: CNT_W] = r_err_cnt[l];
    end
`endif

endmodule

// File: tb/tb_diff_prog_delay_line.sv
// Directed self-checking bench for diff_prog_delay_line (4 lanes, max depth 16).
// Latency: checks exact in->out latency, SETTLE length, clamping and reset behaviour.
// Backpressure: checks that a load during SETTLE is dropped.
module tb_diff_prog_delay_line;

    localparam int LANES     = 4;
    localparam int MAX_DELAY = 16;
    localparam int DELAY_W   = 5;
    localparam int CNT_W     = 8;

    localparam logic [LANES-1:0] IDLE_P = 4'b0000;
    localparam logic [LANES-1:0] IDLE_N = 4'b1111;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LANES-1:0]       in_p = IDLE_P;
    logic [LANES-1:0]       in_n = IDLE_N;
    logic [DELAY_W-1:0]     delay_sel = '0;
    logic                   delay_load = 1'b0;
    logic                   delay_busy;
    logic [DELAY_W-1:0]     cur_delay;
    logic [LANES-1:0]       out_p;
    logic [LANES-1:0]       out_n;
    logic [LANES-1:0]       out_valid;
`ifdef DIFF_DELAY_ERR_CNT_EN
    logic                   err_clr = 1'b0;
    logic [LANES*CNT_W-1:0] err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    diff_prog_delay_line #(
        .LANES     (LANES),
        .MAX_DELAY (MAX_DELAY),
        .DELAY_W   (DELAY_W),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_in_p       (in_p),
        .i_in_n       (in_n),
        .i_delay_sel  (delay_sel),
        .i_delay_load (delay_load),
        .o_delay_busy (delay_busy),
        .o_cur_delay  (cur_delay),
        .o_out_p      (out_p),
        .o_out_n      (out_n),
        .o_out_valid  (out_valid)
`ifdef DIFF_DELAY_ERR_CNT_EN
        ,
        .i_err_clr    (err_clr),
        .o_err_cnt    (err_cnt)
`endif
    );

    typedef struct {
        logic [DELAY_W-1:0] sel;
        logic [DELAY_W-1:0] exp_cur;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a depth; returns the number of cycles busy was observed high (bounded)
    task automatic load_and_count(input logic [DELAY_W-1:0] sel, output int busy_cycles);
        delay_sel  = sel;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        busy_cycles = 0;
        while (delay_busy && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
    endtask

    // One-cycle 1/0 pulse on lane 0; it must appear exactly d cycles later and nowhere else
    task automatic pulse_latency(input int d);
        in_p = 4'b0001;
        in_n = 4'b1110;
        for (int k = 1; k <= d; k++) begin
            tick();
            if (k == 1) begin
                in_p = IDLE_P;
                in_n = IDLE_N;
            end
            chk($sformatf("lat%0d_out_p0_k%0d", d, k), 32'(out_p[0]), 32'(k == d));
        end
        chk($sformatf("lat%0d_out_n0", d), 32'(out_n[0]), 32'd0);
        chk($sformatf("lat%0d_valid", d), 32'(out_valid), 32'hF);
        tick();
        chk($sformatf("lat%0d_after_p0", d), 32'(out_p[0]), 32'd0);
    endtask

    initial begin
        int bc;
        logic [DELAY_W-1:0] cur_before;

        tbl[0] = '{sel: 5'd0,  exp_cur: 5'd2};
        tbl[1] = '{sel: 5'd1,  exp_cur: 5'd2};
        tbl[2] = '{sel: 5'd2,  exp_cur: 5'd2};
        tbl[3] = '{sel: 5'd7,  exp_cur: 5'd7};
        tbl[4] = '{sel: 5'd16, exp_cur: 5'd16};
        tbl[5] = '{sel: 5'd17, exp_cur: 5'd16};
        tbl[6] = '{sel: 5'd31, exp_cur: 5'd16};

        // Reset, with a load request held during reset: reset must win
        delay_sel  = 5'd5;
        delay_load = 1'b1;
        tick();
        tick();
        chk("rst_cur_delay", 32'(cur_delay), 32'd16);
        chk("rst_busy", 32'(delay_busy), 32'd0);
        delay_load = 1'b0;
        rst = 1'b0;
        chk("rst_out_p", 32'(out_p), 32'h0);
        chk("rst_out_n", 32'(out_n), 32'hF);
        chk("rst_valid", 32'(out_valid), 32'hF);
        tick();
        chk("post_rst_busy", 32'(delay_busy), 32'd0);

        // Default depth 16
        pulse_latency(16);

        // Reprogram to 5 while lane 1 changes: outputs frozen, valid masked
        delay_sel  = 5'd5;
        delay_load = 1'b1;
        in_p = 4'b0010;
        in_n = 4'b1101;
        tick();
        delay_load = 1'b0;
        chk("t2_cur_delay", 32'(cur_delay), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_busy_%0d", k), 32'(delay_busy), 32'd1);
            chk($sformatf("t2_frz_p_%0d", k), 32'(out_p), 32'h0);
            chk($sformatf("t2_frz_n_%0d", k), 32'(out_n), 32'hF);
            chk($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'h0);
            tick();
        end
        chk("t2_busy_end", 32'(delay_busy), 32'd0);
        in_p = IDLE_P;
        in_n = IDLE_N;
        for (int k = 0; k < 20; k++) tick();
        pulse_latency(5);

        // Clamping table: reported depth and SETTLE length
        for (int i = 0; i < 7; i++) begin
            load_and_count(tbl[i].sel, bc);
            chk($sformatf("clamp_cur_sel%0d", tbl[i].sel), 32'(cur_delay), 32'(tbl[i].exp_cur));
            chk($sformatf("clamp_busy_len_sel%0d", tbl[i].sel), 32'(bc), 32'(tbl[i].exp_cur));
            for (int k = 0; k < 20; k++) tick();
        end
        // Clamp to 2 followed by a latency check at the minimum depth
        load_and_count(5'd0, bc);
        for (int k = 0; k < 20; k++) tick();
        pulse_latency(2);

        // Load with sel=3 on the 2nd SETTLE cycle must be ignored
        delay_sel  = 5'd8;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        tick();
        cur_before = cur_delay;
        delay_sel  = 5'd3;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        chk("t4_cur_kept", 32'(cur_delay), 32'd8);
        chk("t4_cur_before", 32'(cur_before), 32'd8);
        bc = 0;
        while (delay_busy && bc < 40) begin
            bc++;
            tick();
        end
        chk("t4_busy_remaining", 32'(bc), 32'd6);
        chk("t4_cur_final", 32'(cur_delay), 32'd8);

        // Reset mid-SETTLE takes effect immediately
        delay_sel  = 5'd4;
        delay_load = 1'b1;
        tick();
        delay_load = 1'b0;
        tick();
        chk("t6_busy_before", 32'(delay_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_busy", 32'(delay_busy), 32'd0);
        chk("t6_cur_delay", 32'(cur_delay), 32'd16);
        chk("t6_out_n", 32'(out_n), 32'hF);
        chk("t6_out_p", 32'(out_p), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_after", 32'(delay_busy), 32'd0);

        // Lane 2 held invalid (p==n) for 300 cycles
        in_p = 4'b0100;
        in_n = 4'b1111;
        for (int k = 0; k < 300; k++) tick();
        chk("t5_valid", 32'(out_valid), 32'hB);
`ifdef DIFF_DELAY_ERR_CNT_EN
        chk("t5_cnt0", 32'(err_cnt[0*CNT_W +: CNT_W]), 32'd0);
        chk("t5_cnt1", 32'(err_cnt[1*CNT_W +: CNT_W]), 32'd0);
        chk("t5_cnt2", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd255);
        chk("t5_cnt3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr_wins", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd0);
        tick();
        chk("t5_recount", 32'(err_cnt[2*CNT_W +: CNT_W]), 32'd1);
`endif
        in_p = IDLE_P;
        in_n = IDLE_N;
        for (int k = 0; k < 20; k++) tick();
        chk("t5_valid_recovered", 32'(out_valid), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
